// File: rtl/scic_mem_pkg.sv
// scic_mem_pkg: shared memory-subsystem types and defaults for the RAM, CPU and access controller
package scic_mem_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int MEM_DEPTH = 32;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, COMPLETE} state_t;
endpackage

// File: rtl/ram_access_controller.sv
// ram_access_controller: sequences CPU req/done transfers into range-checked, wait-stated RAM cycles
module ram_access_controller #(
  parameter int DATA_WIDTH = scic_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = scic_mem_pkg::ADDR_WIDTH,
  parameter int MEM_DEPTH = scic_mem_pkg::MEM_DEPTH,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  rw,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_we,
  output logic                  ram_chip_select,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  import scic_mem_pkg::*;
  state_t state;
  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mdr;
  logic rw_l;
  logic [3:0] cnt;
  logic accept, oor;
  assign accept = req && (state == IDLE || state == COMPLETE);
  assign oor = addr >= 32'(MEM_DEPTH);
  // Controls decode from state alone, so reset drops ram_we before the next falling edge
  assign busy = state == SETUP || state == ACCESS;
  assign done = state == COMPLETE;
  assign ram_chip_select = busy;
  assign ram_we = state == ACCESS && rw_l == RW_WRITE;
  assign ram_address = mar;
  assign ram_data_in = mdr;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mar <= '0;
      mdr <= '0;
      rw_l <= RW_READ;
      err <= 1'b0;
      rdata <= '0;
      cnt <= '0;
    end else if (accept) begin
      mar <= addr[ADDR_WIDTH-1:0];
      mdr <= wdata;
      rw_l <= rw;
      err <= oor;
      state <= oor ? COMPLETE : SETUP;
    end else begin
      case (state)
        SETUP: begin
          cnt <= 4'(WAIT_STATES - 1);
          state <= ACCESS;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (rw_l == RW_READ) rdata <= ram_data_out;
            state <= COMPLETE;
          end else cnt <= cnt - 4'd1;
        end
        COMPLETE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_access_controller.sv
// tb_ram_access_controller: randomized transaction-level check of two controllers (1 and 4 wait states)
module tb_ram_access_controller;
  logic clk = 1'b0;
  logic load;
  logic rst_n [2];
  logic req [2], rw [2];
  logic [31:0] addr [2], wdata [2];
  logic busy [2], done [2], err [2], ram_we [2], ram_cs [2];
  logic [31:0] rdata [2], ram_din [2], ram_dout [2];
  logic [4:0] ram_addr [2];
  logic [31:0] mem [2][32];
  logic [31:0] exp_mem [2][32];
  logic [31:0] exp_rdata [2];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ram_access_controller #(.WAIT_STATES(1)) dut0 (
    .clock(clk), .reset_n(rst_n[0]), .req(req[0]), .rw(rw[0]), .addr(addr[0]), .wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .rdata(rdata[0]), .ram_address(ram_addr[0]),
    .ram_data_in(ram_din[0]), .ram_we(ram_we[0]), .ram_chip_select(ram_cs[0]), .ram_data_out(ram_dout[0]));
  ram_access_controller #(.WAIT_STATES(4)) dut1 (
    .clock(clk), .reset_n(rst_n[1]), .req(req[1]), .rw(rw[1]), .addr(addr[1]), .wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .rdata(rdata[1]), .ram_address(ram_addr[1]),
    .ram_data_in(ram_din[1]), .ram_we(ram_we[1]), .ram_chip_select(ram_cs[1]), .ram_data_out(ram_dout[1]));
  assign ram_dout[0] = mem[0][ram_addr[0]];
  assign ram_dout[1] = mem[1][ram_addr[1]];
  // Behavioural 32x32 RAMs: falling-edge write, combinational read
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load) begin
        for (int a = 0; a < 32; a++) mem[i][a] = exp_mem[i][a];
      end else if (ram_we[i] && ram_cs[i]) mem[i][ram_addr[i]] = ram_din[i];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_idle_outputs(input int i);
    chk("rst_busy", 32'(busy[i]), 0);
    chk("rst_done", 32'(done[i]), 0);
    chk("rst_err", 32'(err[i]), 0);
    chk("rst_we", 32'(ram_we[i]), 0);
    chk("rst_cs", 32'(ram_cs[i]), 0);
    chk("rst_rdata", rdata[i], 0);
    chk("rst_mar", 32'(ram_addr[i]), 0);
    chk("rst_mdr", ram_din[i], 0);
  endtask
  task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d, input bit noise);
    int k = 0, cs_n = 0, bad_we = 0;
    int ws = (i == 1) ? 4 : 1;
    bit oor = a >= 32;
    @(negedge clk);
    req[i] = 1'b1; rw[i] = w; addr[i] = a; wdata[i] = d;
    @(posedge clk);
    forever begin
      @(negedge clk);
      k++;
      if (ram_we[i] && !ram_cs[i]) bad_we++;
      if (ram_cs[i]) cs_n++;
      if (done[i] || k > 30) break;
      req[i] = noise ? 1'($urandom) : 1'b0;
      addr[i] = $urandom; wdata[i] = $urandom; rw[i] = 1'($urandom);
    end
    req[i] = 1'b0;
    if (!oor) begin
      if (w) exp_mem[i][a[4:0]] = d;
      else exp_rdata[i] = exp_mem[i][a[4:0]];
    end
    chk("latency", k, oor ? 1 : 2 + ws);
    chk("err", 32'(err[i]), 32'(oor));
    chk("cs_cycles", cs_n, oor ? 0 : 1 + ws);
    chk("we_without_cs", bad_we, 0);
    chk("rdata", rdata[i], exp_rdata[i]);
    @(negedge clk);
    chk("done_pulse", 32'(done[i]), 0);
    chk("err_held", 32'(err[i]), 32'(oor));
  endtask
  task automatic back_to_back();
    logic [31:0] d3 = $urandom, d4 = $urandom;
    int t [3];
    int k = 0, n = 0;
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 3; wdata[0] = d3;
    while (n < 3 && k < 40) begin
      @(negedge clk);
      k++;
      if (done[0]) begin
        t[n] = k;
        chk("b2b_err", 32'(err[0]), 0);
        n++;
        if (n == 1) begin rw[0] = 1'b1; addr[0] = 4; wdata[0] = d4; end
        else if (n == 2) begin rw[0] = 1'b0; addr[0] = 3; wdata[0] = $urandom; end
        else req[0] = 1'b0;
      end
    end
    req[0] = 1'b0;
    exp_mem[0][3] = d3;
    exp_mem[0][4] = d4;
    exp_rdata[0] = d3;
    chk("b2b_count", n, 3);
    chk("b2b_first", t[0], 3);
    chk("b2b_gap1", t[1] - t[0], 3);
    chk("b2b_gap2", t[2] - t[1], 3);
    chk("b2b_rdata", rdata[0], d3);
  endtask
  initial begin
    load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; wdata[i] = '0; exp_rdata[i] = '0;
      for (int a = 0; a < 32; a++) exp_mem[i][a] = $urandom;
    end
    repeat (3) @(negedge clk);
    load = 1'b0;
    check_idle_outputs(0);
    check_idle_outputs(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    check_idle_outputs(0);
    check_idle_outputs(1);
    txn(0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0);
    txn(0, 1'b0, 5, 32'h0, 1'b0);
    chk("readback_5", rdata[0], 32'hDEAD_BEEF);
    txn(0, 1'b0, 32, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h0000_0105, 32'h0, 1'b0);
    chk("oor_rdata_kept", rdata[0], 32'hDEAD_BEEF);
    txn(0, 1'b1, 31, 32'h1234_5678, 1'b0);
    txn(0, 1'b0, 31, 32'h0, 1'b0);
    chk("readback_31", rdata[0], 32'h1234_5678);
    txn(0, 1'b0, 0, 32'h0, 1'b0);
    back_to_back();
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 7; wdata[0] = ~exp_mem[0][7];
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    @(posedge clk);
    #1 rst_n[0] = 1'b0;
    #1 chk("reset_we_drop", 32'(ram_we[0]), 0);
    chk("reset_cs_drop", 32'(ram_cs[0]), 0);
    repeat (2) @(negedge clk);
    exp_rdata[0] = '0;
    check_idle_outputs(0);
    rst_n[0] = 1'b1;
    txn(0, 1'b0, 7, 32'h0, 1'b0);
    txn(1, 1'b1, 9, 32'hCAFE_F00D, 1'b1);
    txn(1, 1'b0, 9, 32'h0, 1'b1);
    chk("ws4_readback", rdata[1], 32'hCAFE_F00D);
    for (int n = 0; n < 60; n++) begin
      int sel = int'($urandom_range(0, 7));
      logic [31:0] a = (sel == 0) ? $urandom : (sel == 1) ? 32 + $urandom_range(0, 3) : 32'($urandom_range(0, 31));
      txn(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom, 1'($urandom));
    end
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 32; a++) chk("ram_contents", mem[i][a], exp_mem[i][a]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_access_controller.md
Name: ram_access_controller

Overview:
- Sequencer directly upstream of the 32x32 data RAM. Converts a CPU-side request/done handshake into RAM control: address, data_in, we, chip_select.
- Latches the address into an internal MAR and write data into an internal MDR.
- Range-checks the full 32-bit address against MEM_DEPTH.
- Holds chip_select for a programmable number of access cycles and captures read data into rdata.
- The RAM writes on the falling clock edge and reads combinationally. This block runs on the rising edge, so all RAM controls are stable across each falling edge.

Parameters:
- DATA_WIDTH, 32, word width of the CPU and RAM data paths.
- ADDR_WIDTH, 5, RAM address width.
- MEM_DEPTH, 32, number of valid words; a CPU address >= MEM_DEPTH is out of range.
- WAIT_STATES, 1, number of ACCESS cycles per transfer. Legal range is 1..15.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- req, input, 1, CPU request; sampled only when accepting.
- rw, input, 1, 1 = write, 0 = read.
- addr, input, 32, CPU word address.
- wdata, input, DATA_WIDTH, CPU write data.
- busy, output, 1, high in SETUP and ACCESS.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, out-of-range flag; valid while done is high and held until the next accept.
- rdata, output, DATA_WIDTH, last successfully read word.
- ram_address, output, ADDR_WIDTH, driven from the MAR.
- ram_data_in, output, DATA_WIDTH, driven from the MDR.
- ram_we, output, 1, RAM write enable.
- ram_chip_select, output, 1, RAM select.
- ram_data_out, input, DATA_WIDTH, combinational RAM read data.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE.
  - busy, done, err, ram_we and ram_chip_select = 0.
  - rdata, MAR and MDR = 0.
  - ram_we falls immediately, so no RAM write occurs at the next falling edge even if reset lands mid-ACCESS.
- States: IDLE, SETUP, ACCESS, COMPLETE. All are registered; the outputs listed above are registered or decoded from state only.
- Accept condition: req = 1 and state is IDLE or COMPLETE. Back-to-back requests are accepted in the COMPLETE cycle. req in SETUP or ACCESS is ignored; there is no queueing.
- On accept:
  - MAR <= addr[ADDR_WIDTH-1:0]; MDR <= wdata; latch rw; err <= 0.
  - If addr >= MEM_DEPTH (full 32-bit compare): go to COMPLETE with err <= 1. No RAM cycle occurs; chip_select stays 0.
  - Otherwise go to SETUP.
- SETUP (one cycle): ram_chip_select = 1, ram_we = 0, address and data stable. Load wait counter with WAIT_STATES-1. Next state is ACCESS.
- ACCESS (WAIT_STATES cycles): ram_chip_select = 1; ram_we = latched rw.
  - Counter decrements each rising edge.
  - At the rising edge where the counter is 0: for a read, rdata <= ram_data_out. Then go to COMPLETE.
  - Repeated falling-edge writes of the same MDR value are permitted.
- COMPLETE (one cycle): done = 1, chip_select = 0, we = 0. Next state is SETUP or COMPLETE if a new request is accepted, otherwise IDLE.
- Latency, in-range access: the accept edge is E0; done is high during the cycle after edge E(1+WAIT_STATES). With WAIT_STATES = 1, done is sampled high at E3.
- Latency, out-of-range: done is sampled high at E1.
- rdata changes only on a completed in-range read. Writes and errors leave it unchanged.
- ram_we is never 1 while ram_chip_select is 0.
- Address MAR = MEM_DEPTH-1 (31) is legal and there is no wrap. Address 32 or any value with upper bits set raises err.

Decomposition:
- Shared package scic_mem_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, COMPLETE};
  - constants RW_READ = 0 and RW_WRITE = 1;
  - DATA_WIDTH, ADDR_WIDTH and MEM_DEPTH defaults, for reuse by the RAM and CPU.
- No sub-module. The wait counter is an inline 4-bit down-counter.

Test Plan:
- Reset: hold reset_n = 0, then release → all outputs 0. Assert reset_n = 0 mid-ACCESS of a write to address 7 → ram_we drops immediately and a later read of address 7 returns the old value.
- Write then read, WAIT_STATES = 1: req, rw = 1, addr = 5, wdata = 32'hDEADBEEF → done at E3 with err = 0. Then a read of addr = 5 → rdata = 32'hDEADBEEF at done.
- Out of range: read with addr = 32 → done at E1, err = 1, ram_chip_select never 1, rdata unchanged. addr = 32'h0000_0105 → err = 1.
- Boundary address: write addr = 31 with value 32'h1234_5678, then read back → match, err = 0. Address 0 is untouched.
- Back-to-back: req held high for three requests (write 3, write 4, read 3) → each accepted in the COMPLETE cycle. done pulses every 3 cycles; final rdata = write-3 data.
- Busy-ignore and wait states: WAIT_STATES = 4; a req toggled during SETUP/ACCESS is ignored. ram_chip_select is high for exactly 5 cycles, and done is sampled high at E6.
